// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with a programmable count window
// [MIN_VAL, MAX_VAL], a per-cycle variable step, a count enable, and a choice
// of wrap or saturate at the window limits. Terminal-count flags are decoded
// combinationally from the count. Overflow and underflow are one-cycle
// registered pulses.
module updown_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 255,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              control,
  input  logic [WIDTH-1:0]  I,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  q,
  output logic              tc_max,
  output logic              tc_min,
  output logic              ovf,
  output logic              unf
);

  // Arithmetic width: wide enough that q + step + RANGE never truncates.
  localparam int AW = WIDTH + STEP_W + 1;

  localparam logic [AW-1:0]    MIN_A   = AW'(MIN_VAL);
  localparam logic [AW-1:0]    MAX_A   = AW'(MAX_VAL);
  localparam logic [AW-1:0]    RANGE_A = AW'(MAX_VAL - MIN_VAL + 1);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [AW-1:0] q_a, i_a, step_a, s_a;
  logic [AW-1:0] sum_a, diff_a, nq_a;
  logic          up_cross, dn_cross;

  // Datapath: effective step, both candidate results, and crossing detection.
  // The down path tests q < MIN + s instead of forming a negative difference,
  // and the wrapped value is q + RANGE - s, which stays non-negative since
  // s <= RANGE.
  always_comb begin
    q_a      = AW'(q_q);
    i_a      = AW'(I);
    step_a   = AW'(step);
    s_a      = (step_a > RANGE_A) ? RANGE_A : step_a;
    sum_a    = q_a + s_a;
    up_cross = (sum_a > MAX_A);
    dn_cross = (q_a < (MIN_A + s_a));
    diff_a   = dn_cross ? (q_a + RANGE_A - s_a) : (q_a - s_a);
    nq_a     = up_cross ? (sum_a - RANGE_A) : sum_a;
  end

  // Next-state selection: load beats count. Pulses default low.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (load) begin
      if (i_a > MAX_A)      q_d = MAX_W;
      else if (i_a < MIN_A) q_d = MIN_W;
      else                  q_d = I;
    end else if (en) begin
      if (control) begin
        ovf_d = up_cross;
        if (up_cross && (SATURATE != 0)) q_d = MAX_W;
        else                             q_d = nq_a[WIDTH-1:0];
      end else begin
        unf_d = dn_cross;
        if (dn_cross && (SATURATE != 0)) q_d = MIN_W;
        else                             q_d = diff_a[WIDTH-1:0];
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= MIN_W;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // The upper bits of the wide results are zero whenever they are selected.
  logic unused_hi;
  assign unused_hi = ^{nq_a[AW-1:WIDTH], diff_a[AW-1:WIDTH]};

  assign q      = q_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign tc_max = (q_q == MAX_W);
  assign tc_min = (q_q == MIN_W);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param. Three instances share one set of inputs:
//   0: window 0..15 wrap, 1: window 3..10 wrap, 2: window 3..10 saturate.
// Each is checked every edge against an arithmetic model of the counting
// rules; directed steps also check hand-derived constants.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       control = 1'b1;
  logic [3:0] I = '0;
  logic [3:0] step = '0;

  logic [3:0] dq [3];
  logic       dtmax [3];
  logic       dtmin [3];
  logic       dovf [3];
  logic       dunf [3];

  int errors = 0;
  int checks = 0;

  // Model state and per-instance window configuration.
  int mn [3]  = '{0, 3, 3};
  int mx [3]  = '{15, 10, 10};
  bit sat [3] = '{1'b0, 1'b0, 1'b1};
  int mq [3];
  bit movf [3];
  bit munf [3];

  // Clock.
  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .STEP_W(4), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .control(control), .I(I), .step(step),
    .q(dq[0]), .tc_max(dtmax[0]), .tc_min(dtmin[0]), .ovf(dovf[0]), .unf(dunf[0]));

  updown_counter_param #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(10), .STEP_W(4), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .control(control), .I(I), .step(step),
    .q(dq[1]), .tc_max(dtmax[1]), .tc_min(dtmin[1]), .ovf(dovf[1]), .unf(dunf[1]));

  updown_counter_param #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(10), .STEP_W(4), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .load(load), .control(control), .I(I), .step(step),
    .q(dq[2]), .tc_max(dtmax[2]), .tc_min(dtmin[2]), .ovf(dovf[2]), .unf(dunf[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: one rising edge applied to all three windows.
  task automatic model_edge();
    int rng, s, t;
    for (int k = 0; k < 3; k++) begin
      rng = mx[k] - mn[k] + 1;
      movf[k] = 1'b0;
      munf[k] = 1'b0;
      if (rst) begin
        mq[k] = mn[k];
      end else if (load) begin
        t = int'(I);
        mq[k] = (t > mx[k]) ? mx[k] : ((t < mn[k]) ? mn[k] : t);
      end else if (en) begin
        s = (int'(step) < rng) ? int'(step) : rng;
        if (control) begin
          t = mq[k] + s;
          if (t > mx[k]) begin
            movf[k] = 1'b1;
            mq[k] = sat[k] ? mx[k] : t - rng;
          end else mq[k] = t;
        end else begin
          t = mq[k] - s;
          if (t < mn[k]) begin
            munf[k] = 1'b1;
            mq[k] = sat[k] ? mn[k] : t + rng;
          end else mq[k] = t;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s[%0d].q", tag, k), int'(dq[k]), mq[k]);
      chk($sformatf("%s[%0d].tc_max", tag, k), int'(dtmax[k]), int'(mq[k] == mx[k]));
      chk($sformatf("%s[%0d].tc_min", tag, k), int'(dtmin[k]), int'(mq[k] == mn[k]));
      chk($sformatf("%s[%0d].ovf", tag, k), int'(dovf[k]), int'(movf[k]));
      chk($sformatf("%s[%0d].unf", tag, k), int'(dunf[k]), int'(munf[k]));
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input bit c,
                       input int iv, input int sv);
    rst = r; load = l; en = e; control = c;
    I = 4'(iv); step = 4'(sv);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
    end

    // Reset beats a simultaneous load and count.
    drive(1, 1, 1, 1, 9, 1);
    tick("reset");
    chk("reset_a_q", int'(dq[0]), 0);
    chk("reset_a_tc_min", int'(dtmin[0]), 1);
    chk("reset_b_q", int'(dq[1]), 3);

    // Full-range wrap on window 0..15.
    drive(0, 1, 0, 1, 9, 1);
    tick("wrap_load");
    drive(0, 0, 1, 1, 0, 1);
    for (int n = 0; n < 6; n++) tick("wrap_up");
    chk("wrap_a_q15", int'(dq[0]), 15);
    chk("wrap_a_tc_max", int'(dtmax[0]), 1);
    tick("wrap_edge");
    chk("wrap_a_q0", int'(dq[0]), 0);
    chk("wrap_a_ovf", int'(dovf[0]), 1);
    tick("wrap_after");
    chk("wrap_a_ovf_drop", int'(dovf[0]), 0);

    // Window wrap (instance 1) and saturate (instance 2), step 3.
    drive(0, 1, 0, 1, 9, 3);
    tick("win_load");
    drive(0, 0, 1, 1, 0, 3);
    tick("win_up");
    chk("win_b_q4", int'(dq[1]), 4);
    chk("win_b_ovf", int'(dovf[1]), 1);
    chk("sat_c_q10", int'(dq[2]), 10);
    tick("sat_up2");
    chk("sat_c_hold10", int'(dq[2]), 10);
    chk("sat_c_ovf_again", int'(dovf[2]), 1);
    drive(0, 1, 0, 1, 9, 3);
    tick("win_reload");
    drive(0, 0, 1, 1, 0, 3);
    tick("win_up_b");
    drive(0, 0, 1, 0, 0, 3);
    tick("win_dn1");
    chk("win_b_q9", int'(dq[1]), 9);
    chk("win_b_unf", int'(dunf[1]), 1);
    tick("win_dn2");
    chk("win_b_q6", int'(dq[1]), 6);
    chk("win_b_no_unf", int'(dunf[1]), 0);
    // Instance 2 went 10 -> 7 -> 4; next down clamps at 3 with a pulse.
    chk("sat_c_q4", int'(dq[2]), 4);
    chk("sat_c_no_unf", int'(dunf[2]), 0);
    tick("sat_dn3");
    chk("sat_c_q3", int'(dq[2]), 3);
    chk("sat_c_unf", int'(dunf[2]), 1);

    // Load clamping into the window.
    drive(0, 1, 1, 0, 14, 3);
    tick("clamp_hi");
    chk("clamp_b_q10", int'(dq[1]), 10);
    chk("clamp_b_tc_max", int'(dtmax[1]), 1);
    drive(0, 1, 1, 1, 1, 3);
    tick("clamp_lo");
    chk("clamp_b_q3", int'(dq[1]), 3);
    chk("clamp_b_tc_min", int'(dtmin[1]), 1);

    // Hold, count, direction change, mid-count reset.
    drive(0, 1, 0, 1, 4, 2);
    tick("hold_load");
    drive(0, 0, 0, 1, 0, 2);
    for (int n = 0; n < 3; n++) tick("hold");
    chk("hold_a_q4", int'(dq[0]), 4);
    drive(0, 0, 1, 1, 0, 2);
    tick("cnt1");
    tick("cnt2");
    chk("cnt_a_q8", int'(dq[0]), 8);
    drive(0, 0, 1, 0, 0, 2);
    tick("dir");
    chk("dir_a_q6", int'(dq[0]), 6);
    drive(1, 0, 1, 0, 0, 2);
    tick("midrst");
    chk("midrst_a_q0", int'(dq[0]), 0);

    // Step of zero with enable: hold, no pulses.
    drive(0, 1, 0, 1, 15, 0);
    tick("zero_load");
    drive(0, 0, 1, 1, 0, 0);
    tick("zero_step");
    chk("zero_a_q15", int'(dq[0]), 15);
    chk("zero_a_ovf", int'(dovf[0]), 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 15));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
